// File: rtl/seq_adder.sv
// Chunk-serial adder/subtractor: CHUNK bits per clock, ready/valid handshake on both sides.
// state | meaning -- IDLE: wait for operands | RUN: add one chunk per cycle | DONE: hold result until taken
module seq_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             r_ovf;

  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic [CHUNK:0]   w_csum;
  logic             w_last;
  logic             w_ovf;

  assign w_ca   = r_a[int'(r_idx) * CHUNK +: CHUNK];
  assign w_cb   = r_b[int'(r_idx) * CHUNK +: CHUNK];
  assign w_csum = {1'b0, w_ca} + {1'b0, w_cb} + {{CHUNK{1'b0}}, r_carry};
  assign w_last = (r_idx == LAST_IDX);
  // Same as carry-into-MSB xor carry-out-of-MSB, but valid for any CHUNK >= 1.
  assign w_ovf  = (w_ca[CHUNK-1] ~^ w_cb[CHUNK-1]) & (w_csum[CHUNK-1] ^ w_ca[CHUNK-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + ~borrow, so invert both on the way in.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? ~c_in : c_in;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum[int'(r_idx) * CHUNK +: CHUNK] <= w_csum[CHUNK-1:0];
          r_carry <= w_csum[CHUNK];
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_c_out <= w_csum[CHUNK];
            r_ovf   <= w_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign c_out     = r_c_out;
  assign ovf       = r_ovf;

endmodule

// File: doc/seq_adder.md
SEQ_ADDER -- requirements
Module: seq_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; SHALL be a positive multiple of CHUNK.
REQ-002 Parameter CHUNK, default 8: bits added per clock cycle; NCHUNK = WIDTH/CHUNK.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port in_valid, input, 1: the operand set on a, b, c_in and sub is valid.
REQ-007 Port in_ready, output, 1: the block accepts an operand set.
REQ-008 Port a, input, WIDTH: operand A.
REQ-009 Port b, input, WIDTH: operand B.
REQ-010 Port c_in, input, 1: carry-in when sub=0, borrow-in when sub=1.
REQ-011 Port sub, input, 1: 0 selects a+b+c_in; 1 selects a-b-c_in.
REQ-012 Port out_valid, output, 1: the result on sum, c_out and ovf is valid.
REQ-013 Port out_ready, input, 1: the consumer accepts the result.
REQ-014 Port sum, output, WIDTH: result, modulo 2^WIDTH.
REQ-015 Port c_out, output, 1: raw carry out of the MSB; in subtract mode 1 means no borrow.
REQ-016 Port ovf, output, 1: two's-complement signed overflow.

Function
REQ-017 FSM states SHALL be IDLE, RUN and DONE; in_ready SHALL be 1 exactly in IDLE, and out_valid SHALL be 1 exactly in DONE.
REQ-018 In IDLE, an edge with in_valid=1 SHALL latch a, (sub ? ~b : b), and carry (sub ? ~c_in : c_in), clear the chunk index to 0 and go to RUN; with in_valid=0 the FSM SHALL stay in IDLE.
REQ-019 Each RUN cycle SHALL add chunk index i: bits [i*CHUNK +: CHUNK] of the latched A, the latched B and the carry register, write that sum slice, update the carry register and increment i.
REQ-020 At i = NCHUNK-1 the RUN cycle SHALL also capture c_out as the final carry and ovf as (carry into MSB) XOR (carry out of MSB), then go to DONE.
REQ-021 Latency: for an accept at edge k, out_valid SHALL rise after edge k+NCHUNK.
REQ-022 In DONE with out_ready=1, the FSM SHALL go to IDLE at the next edge; in_ready SHALL be 0 until that edge, so there is no pass-through or overlap.
REQ-023 In DONE with out_ready=0, sum, c_out and ovf SHALL hold stable, and in_valid SHALL be ignored.
REQ-024 sum, c_out and ovf SHALL keep the last result after return to IDLE until the next final RUN cycle; partial sum slices MAY change during RUN.
REQ-025 Operand inputs SHALL be sampled only at the accept edge; changes to them during RUN or DONE SHALL NOT affect the result.
REQ-026 When WIDTH=CHUNK, RUN SHALL last exactly one cycle, giving a latency of 1.

Reset
REQ-027 While rst_n=0, the block SHALL be asynchronously forced to: state IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, ovf=0, chunk index 0, carry register 0.
REQ-028 Assertion of rst_n during RUN or DONE SHALL abort the operation and discard its result; after release the block SHALL be in IDLE.
REQ-029 The first rising clk edge after rst_n deasserts MAY accept an operand set.

Verification
REQ-030 With WIDTH=32, CHUNK=8: accept a=0xFFFFFFFF, b=0x1, c_in=0, sub=0 -> out_valid rises 4 cycles after the accept with sum=0x00000000, c_out=1, ovf=0.
REQ-031 With WIDTH=32, CHUNK=8: a=0x7FFFFFFF, b=0x1, c_in=0, sub=0 -> sum=0x80000000, c_out=0, ovf=1.
REQ-032 With WIDTH=32, CHUNK=8: a=5, b=7, c_in=0, sub=1 -> sum=0xFFFFFFFE, c_out=0, ovf=0; a=7, b=5, c_in=1, sub=1 -> sum=0x1, c_out=1.
REQ-033 Backpressure: hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands -> sum, c_out and ovf stay stable, in_ready=0, and no new accept occurs until the edge after out_ready=1.
REQ-034 Reset mid-operation: drive rst_n=0 during the second RUN cycle -> out_valid=0, sum=0 and in_ready=1 immediately; the next operation after release produces the correct result.
REQ-035 With WIDTH=8, CHUNK=8: a=0xC8, b=0x64, c_in=1, sub=0 -> sum=0x2D, c_out=1, ovf=0, latency 1.
